// File: rtl/morse_decoder_pkg.sv
// Shared types and constants for the Morse receiver: state encoding,
// letter indices and default timing thresholds.
package morse_decoder_pkg;

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
    typedef logic [2:0] letter_t;

    localparam letter_t LTR_A = 3'd0;
    localparam letter_t LTR_B = 3'd1;
    localparam letter_t LTR_C = 3'd2;
    localparam letter_t LTR_D = 3'd3;
    localparam letter_t LTR_E = 3'd4;
    localparam letter_t LTR_F = 3'd5;
    localparam letter_t LTR_G = 3'd6;
    localparam letter_t LTR_H = 3'd7;

    localparam int DEF_CNT_W      = 4;
    localparam int DEF_DOT_MAX    = 1;
    localparam int DEF_DASH_MIN   = 3;
    localparam int DEF_DASH_MAX   = 4;
    localparam int DEF_LETTER_GAP = 3;
    localparam int DEF_MAX_SYM    = 4;

endpackage

// File: rtl/morse_decoder_if.sv
// Line-in / letter-out bundle between the Morse source and the decoder.
interface morse_decoder_if;
    import morse_decoder_pkg::*;

    logic    tick;
    logic    din;
    letter_t letter;
    logic    valid;
    logic    error;
    logic    busy;

    modport master (output tick, din, input letter, valid, error, busy);
    modport slave  (input tick, din, output letter, valid, error, busy);
endinterface

// File: rtl/morse_symbol_lookup.sv
// Maps an accumulated (length, dot/dash bits) pair to a letter index.
// Bits are right-aligned: first symbol at bit len-1, unused upper bits zero.
module morse_symbol_lookup
    import morse_decoder_pkg::*;
#(
    parameter int MAX_SYM = DEF_MAX_SYM,
    parameter int SC_W    = $clog2(MAX_SYM + 1)
) (
    input  logic [SC_W-1:0]    len,
    input  logic [MAX_SYM-1:0] bits,
    output letter_t            letter,
    output logic               match
);

    always_comb begin
        letter = LTR_A;
        match  = 1'b1;
        if      (len == SC_W'(2) && bits == MAX_SYM'(2'b01))   letter = LTR_A;
        else if (len == SC_W'(4) && bits == MAX_SYM'(4'b1000)) letter = LTR_B;
        else if (len == SC_W'(4) && bits == MAX_SYM'(4'b1010)) letter = LTR_C;
        else if (len == SC_W'(3) && bits == MAX_SYM'(3'b100))  letter = LTR_D;
        else if (len == SC_W'(1) && bits == MAX_SYM'(1'b0))    letter = LTR_E;
        else if (len == SC_W'(4) && bits == MAX_SYM'(4'b0010)) letter = LTR_F;
        else if (len == SC_W'(3) && bits == MAX_SYM'(3'b110))  letter = LTR_G;
        else if (len == SC_W'(4) && bits == MAX_SYM'(4'b0000)) letter = LTR_H;
        else                                                   match  = 1'b0;
    end

endmodule

// File: rtl/morse_decoder.sv
// Samples the Morse line once per tick, measures mark/space runs, builds
// the dot/dash word and emits a one-cycle valid or error pulse per letter.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DOT_MAX    = DEF_DOT_MAX,
    parameter int DASH_MIN   = DEF_DASH_MIN,
    parameter int DASH_MAX   = DEF_DASH_MAX,
    parameter int LETTER_GAP = DEF_LETTER_GAP,
    parameter int MAX_SYM    = DEF_MAX_SYM
) (
    input  logic      clock,
    input  logic      reset,
    morse_decoder_if.slave bus
);

    localparam int SC_W = $clog2(MAX_SYM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DOT_C    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DMIN_C   = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] DMAX_C   = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(LETTER_GAP);
    localparam logic [SC_W-1:0]  SYM_FULL = SC_W'(MAX_SYM);

    state_t             state;
    logic [CNT_W-1:0]   mark_cnt;
    logic [CNT_W-1:0]   space_cnt;
    logic [MAX_SYM-1:0] sym;
    logic [SC_W-1:0]    sym_cnt;
    logic               bad;
    letter_t            letter_q;
    logic               valid_q;
    logic               error_q;
    logic               busy_q;

    letter_t            lk_letter;
    logic               lk_match;
    logic               is_dot;
    logic               is_dash;
    logic [CNT_W-1:0]   mark_inc;
    logic [CNT_W-1:0]   space_inc;

    morse_symbol_lookup #(.MAX_SYM(MAX_SYM), .SC_W(SC_W)) u_lookup (
        .len    (sym_cnt),
        .bits   (sym),
        .letter (lk_letter),
        .match  (lk_match)
    );

    always_comb begin
        is_dot    = (mark_cnt != '0) && (mark_cnt <= DOT_C);
        is_dash   = (mark_cnt >= DMIN_C) && (mark_cnt <= DMAX_C);
        mark_inc  = (mark_cnt  == CNT_MAX) ? mark_cnt  : mark_cnt  + 1'b1;
        space_inc = (space_cnt == CNT_MAX) ? space_cnt : space_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mark_cnt  <= '0;
            space_cnt <= '0;
            sym       <= '0;
            sym_cnt   <= '0;
            bad       <= 1'b0;
            letter_q  <= LTR_A;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            if (bus.tick) begin
                unique case (state)
                    IDLE: if (bus.din) begin
                        state    <= MARK;
                        mark_cnt <= CNT_W'(1);
                        busy_q   <= 1'b1;
                    end
                    MARK: if (bus.din) begin
                        mark_cnt <= mark_inc;
                    end else begin
                        // A full word or an unclassifiable mark poisons the letter
                        // but the gap is still timed so the error lands at its end.
                        if (sym_cnt == SYM_FULL || !(is_dot || is_dash)) begin
                            bad <= 1'b1;
                        end else begin
                            sym     <= {sym[MAX_SYM-2:0], is_dash};
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                        state     <= SPACE;
                        space_cnt <= CNT_W'(1);
                    end
                    SPACE: if (bus.din) begin
                        state    <= MARK;
                        mark_cnt <= CNT_W'(1);
                    end else begin
                        space_cnt <= space_inc;
                        if (space_inc >= GAP_C) begin
                            if (!bad && lk_match) begin
                                letter_q <= lk_letter;
                                valid_q  <= 1'b1;
                            end else begin
                                error_q  <= 1'b1;
                            end
                            sym     <= '0;
                            sym_cnt <= '0;
                            bad     <= 1'b0;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.letter = letter_q;
    assign bus.valid  = valid_q;
    assign bus.error  = error_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: a string-based decoding model checked
// every cycle, plus literal expectations on the letters decoded.
module tb_morse_decoder;
    import morse_decoder_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    morse_decoder_if bus ();
    morse_decoder dut (.clock(clock), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks runs of the sampled line and spells the letter as a
    // dot/dash string, then looks the string up in the code table.
    string tbl [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    string code;
    int    runlen, gap;
    bit    in_mark, m_busy, m_bad, m_valid, m_error, en;
    int    m_letter;

    always @(posedge clock) begin
        m_valid = 0;
        m_error = 0;
        if (reset) begin
            en = 1; code = ""; runlen = 0; gap = 0;
            in_mark = 0; m_busy = 0; m_bad = 0; m_letter = 0;
        end else if (bus.tick) begin
            if (bus.din) begin
                if (in_mark) runlen = (runlen < 15) ? runlen + 1 : runlen;
                else begin in_mark = 1; runlen = 1; end
                m_busy = 1;
            end else if (m_busy) begin
                if (in_mark) begin
                    in_mark = 0;
                    gap = 1;
                    if (code.len() == 4) m_bad = 1;
                    else if (runlen >= 1 && runlen <= 1) code = {code, "."};
                    else if (runlen >= 3 && runlen <= 4) code = {code, "-"};
                    else m_bad = 1;
                end else begin
                    gap++;
                    if (gap >= 3) begin
                        int idx = -1;
                        for (int i = 0; i < 8; i++) if (code == tbl[i]) idx = i;
                        if (!m_bad && idx >= 0) begin m_letter = idx; m_valid = 1; end
                        else m_error = 1;
                        code = ""; m_bad = 0; m_busy = 0;
                    end
                end
            end
        end
    end

    int nv = 0, ne = 0, vcycles = 0;
    int got [32];

    always @(negedge clock) begin
        if (en) begin
            chk("valid",  int'(bus.valid),  int'(m_valid));
            chk("error",  int'(bus.error),  int'(m_error));
            chk("busy",   int'(bus.busy),   int'(m_busy));
            chk("letter", int'(bus.letter), m_letter);
            if (bus.valid) begin
                vcycles++;
                if (nv < 32) got[nv] = int'(bus.letter);
                nv++;
            end
            if (bus.error) ne++;
        end
    end

    // One tick with the given level, then sp filler cycles with a noisy line.
    task automatic tick_bit(input logic b, input int sp);
        bus.din = b; bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        repeat (sp) begin
            bus.din = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
    endtask

    task automatic send(input string s, input int sp);
        for (int i = 0; i < s.len(); i++) tick_bit(s.getc(i) == "1", sp);
    endtask

    task automatic idle(input int n);
        bus.din = 1'b0; bus.tick = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bus.tick = 1'b0; bus.din = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_letter", int'(bus.letter), 0);
        chk("reset_busy",   int'(bus.busy),   0);

        send("10111000", 0); idle(3);                     // A
        chk("A_count", nv, 1); chk("A_letter", got[0], 0);
        chk("A_noerr", ne, 0); chk("A_busy", int'(bus.busy), 0);

        send("1010101000", 0); send("1000", 0); idle(3);  // H then E
        chk("H_letter", got[1], 7); chk("E_letter", got[2], 4); chk("HE_count", nv, 3);

        send("11000", 0); idle(3);                        // length-2 mark
        chk("amb_err", ne, 1); chk("amb_hold", int'(bus.letter), 4); chk("amb_nv", nv, 3);

        send("101010101000", 0); idle(2);                 // five dots
        chk("five_err", ne, 2);
        send("1110101000", 0); idle(3);                   // D
        chk("D_letter", got[3], 3); chk("D_count", nv, 4);

        send("111111000", 0); idle(2);                    // 6-tick mark
        chk("long_err", ne, 3);
        send("11111111111111111111", 0); idle(4);         // held mark
        chk("held_busy", int'(bus.busy), 1); chk("held_noerr", ne, 3);
        send("000", 0); idle(2);
        chk("held_err", ne, 4);

        send("1110", 0);                                  // B cut short by reset
        reset = 1'b1; bus.tick = 1'b1; bus.din = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus.tick = 1'b0; bus.din = 1'b0;
        chk("rst_busy", int'(bus.busy), 0); chk("rst_letter", int'(bus.letter), 0);
        idle(4);
        chk("rst_nv", nv, 4); chk("rst_ne", ne, 4);
        send("10111000", 0); idle(3);
        chk("postrst_A", got[4], 0); chk("postrst_nv", nv, 5);

        send("11101011101000", 4); idle(3);               // C, spaced ticks
        chk("C_letter", got[5], 2);
        send("111011101000", 4); idle(3);                 // G, spaced ticks
        chk("G_letter", got[6], 6); chk("spaced_nv", nv, 7); chk("spaced_ne", ne, 4);
        chk("pulse_width", vcycles, nv);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
